// File: rtl/drift_accumulator_mc.sv
// Multi-channel signed drift accumulators with round-robin correction offers.
// Optional macro DRIFT_ACC_INVERSE_VIOLATION_EN adds inverse-direction violation handling.
module drift_accumulator_mc #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int LOCKOUT_WIDTH = 8,
  localparam int IDX_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     sync_rst_n,
  input  logic                     clk_en,
  input  logic [CHANNELS-1:0]      enable_i,
  input  logic [CHANNELS-1:0]      clear_i,
  input  logic [CHANNELS-1:0]      drift_detected_i,
  input  logic [CHANNELS-1:0]      drift_late_i,
  input  logic [CHANNELS-1:0]      any_valid_edge_i,
  input  logic [COUNTER_WIDTH-1:0] max_drift_i,
  input  logic [LOCKOUT_WIDTH-1:0] min_lockout_i,
  output logic [CHANNELS-1:0]      overflow_o,
`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
  output logic [CHANNELS-1:0]      inverse_violation_o,
`endif
  output logic                     corr_valid_o,
  input  logic                     corr_ready_i,
  output logic [IDX_W-1:0]         corr_channel_o,
  output logic                     corr_late_o
);

  localparam int ACC_MAX_I = (1 << (COUNTER_WIDTH - 1)) - 1;
  localparam logic signed [COUNTER_WIDTH:0] SUM_MAX = (COUNTER_WIDTH + 1)'(ACC_MAX_I);
  localparam logic signed [COUNTER_WIDTH:0] SUM_MIN = -SUM_MAX;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                          state_q, state_nx;
  logic signed [COUNTER_WIDTH-1:0] acc_q   [CHANNELS];
  logic signed [COUNTER_WIDTH-1:0] acc_nx  [CHANNELS];
  logic        [LOCKOUT_WIDTH-1:0] lock_q  [CHANNELS];
  logic        [LOCKOUT_WIDTH-1:0] lock_nx [CHANNELS];
  logic [CHANNELS-1:0]             det, hit, viol, elig;
  logic                            accept, retract, grant_found;
  logic [IDX_W-1:0]                grant_idx, rr_ptr;
  int                              cand;

  function automatic logic signed [COUNTER_WIDTH:0] unit_step(input logic on, input logic up);
    if (!on) return '0;
    return up ? (COUNTER_WIDTH + 1)'(1) : -(COUNTER_WIDTH + 1)'(1);
  endfunction

  // Widened sum clamped to the symmetric range, so the most-negative code never appears.
  function automatic logic signed [COUNTER_WIDTH-1:0] sat_acc(input logic signed [COUNTER_WIDTH:0] s);
    logic signed [COUNTER_WIDTH:0] c;
    c = s;
    if (s > SUM_MAX)      c = SUM_MAX;
    else if (s < SUM_MIN) c = SUM_MIN;
    return c[COUNTER_WIDTH-1:0];
  endfunction

  function automatic logic signed [COUNTER_WIDTH-1:0] acc_step(
    input logic signed [COUNTER_WIDTH-1:0] a,
    input logic d_on, input logic d_up,
    input logic c_on, input logic c_up);
    logic signed [COUNTER_WIDTH:0] s;
    s = (COUNTER_WIDTH + 1)'(a) + unit_step(d_on, d_up) + unit_step(c_on, c_up);
    return sat_acc(s);
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] mag(input logic signed [COUNTER_WIDTH-1:0] a);
    return a[COUNTER_WIDTH-1] ? -a : a;
  endfunction

  assign accept = (state_q == OFFER) && clk_en && corr_ready_i;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      det[ch] = enable_i[ch] & drift_detected_i[ch];
      hit[ch] = accept && (corr_channel_o == IDX_W'(ch));
`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
      viol[ch] = det[ch] && !clear_i[ch] && (acc_q[ch] != '0) &&
                 (drift_late_i[ch] == acc_q[ch][COUNTER_WIDTH-1]);
`else
      viol[ch] = 1'b0;
`endif
      if (clear_i[ch] || viol[ch])
        acc_nx[ch] = '0;
      else
        acc_nx[ch] = acc_step(acc_q[ch], det[ch], drift_late_i[ch], hit[ch], !corr_late_o);
      // Acceptance resets the lockout even if an edge arrives in the same cycle.
      if (clear_i[ch] || viol[ch] || hit[ch])
        lock_nx[ch] = '0;
      else if (any_valid_edge_i[ch] && (lock_q[ch] != '1))
        lock_nx[ch] = lock_q[ch] + LOCKOUT_WIDTH'(1);
      else
        lock_nx[ch] = lock_q[ch];
      elig[ch] = enable_i[ch] && !clear_i[ch] && (acc_q[ch] != '0) && (acc_nx[ch] != '0) &&
                 (lock_q[ch] >= min_lockout_i);
      overflow_o[ch] = mag(acc_q[ch]) > max_drift_i;
    end
  end

  assign retract = clear_i[corr_channel_o] || !enable_i[corr_channel_o] ||
                   (acc_nx[corr_channel_o] == '0);

  // First eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch]  <= '0;
        lock_q[ch] <= '0;
      end
    end else if (clk_en) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch]  <= acc_nx[ch];
        lock_q[ch] <= lock_nx[ch];
      end
    end
  end

`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
  always_ff @(posedge clk) begin
    if (!sync_rst_n) inverse_violation_o <= '0;
    else             inverse_violation_o <= clk_en ? viol : '0;
  end
`endif

  // Arbiter FSM
  always_ff @(posedge clk) begin
    if (!sync_rst_n)  state_q <= IDLE;
    else if (clk_en)  state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_nx = OFFER;
      OFFER:   if (corr_ready_i || retract) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb corr_valid_o = (state_q == OFFER);

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      corr_channel_o <= '0;
      corr_late_o    <= 1'b0;
      rr_ptr         <= '0;
    end else if (clk_en) begin
      if (state_q == IDLE && grant_found) begin
        corr_channel_o <= grant_idx;
        corr_late_o    <= !acc_q[grant_idx][COUNTER_WIDTH-1];
      end
      if (accept)
        rr_ptr <= (corr_channel_o == IDX_W'(CHANNELS - 1)) ? '0 : corr_channel_o + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_drift_accumulator_mc.sv
// Directed bench for drift_accumulator_mc (4 channels, 4-bit accumulators).
module tb_drift_accumulator_mc;
  localparam int CH = 4;
  localparam int CW = 4;
  localparam int LW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          sync_rst_n;
  logic          clk_en;
  logic [CH-1:0] enable_i, clear_i, drift_detected_i, drift_late_i, any_valid_edge_i;
  logic [CW-1:0] max_drift_i;
  logic [LW-1:0] min_lockout_i;
  logic [CH-1:0] overflow_o;
`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
  logic [CH-1:0] inverse_violation_o;
`endif
  logic          corr_valid_o;
  logic          corr_ready_i;
  logic [IW-1:0] corr_channel_o;
  logic          corr_late_o;

  int n_total = 0;
  int n_bad   = 0;

  drift_accumulator_mc #(.CHANNELS(CH), .COUNTER_WIDTH(CW), .LOCKOUT_WIDTH(LW)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .enable_i(enable_i), .clear_i(clear_i), .drift_detected_i(drift_detected_i),
    .drift_late_i(drift_late_i), .any_valid_edge_i(any_valid_edge_i),
    .max_drift_i(max_drift_i), .min_lockout_i(min_lockout_i), .overflow_o(overflow_o),
`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
    .inverse_violation_o(inverse_violation_o),
`endif
    .corr_valid_o(corr_valid_o), .corr_ready_i(corr_ready_i),
    .corr_channel_o(corr_channel_o), .corr_late_o(corr_late_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // valid / channel sequence for the two-channel arbitration run
  logic [9:0] arb_valid;
  int         arb_chan [10] = '{0, 0, 2, 0, 0, 0, 2, 0, 0, 0};

  initial begin
    sync_rst_n = 1'b0; clk_en = 1'b1; enable_i = 4'b0001; clear_i = '0;
    drift_detected_i = '0; drift_late_i = '1; any_valid_edge_i = '0;
    max_drift_i = 4'd7; min_lockout_i = 8'd1; corr_ready_i = 1'b0;
    arb_valid = 10'b0001010101;

    // reset with detections toggling
    for (int i = 0; i < 2; i++) begin
      drift_detected_i[0] = ~drift_detected_i[0];
      tick();
    end
    check_eq("rst_valid", corr_valid_o, 0);
    check_eq("rst_chan", corr_channel_o, 0);
    check_eq("rst_late", corr_late_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_acc0", dut.acc_q[0], 0);
`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
    check_eq("rst_viol", inverse_violation_o, 0);
`endif
    sync_rst_n = 1'b1;
    drift_detected_i = '0;

    // three late detections on ch0
    drift_detected_i[0] = 1'b1;
    repeat (3) tick();
    drift_detected_i = '0;
    check_eq("late3_acc0", dut.acc_q[0], 3);
    check_eq("late3_novalid", corr_valid_o, 0);
    clear_i[0] = 1'b1; tick(); clear_i = '0;
    check_eq("clear_acc0", dut.acc_q[0], 0);

    // saturation at +7 on ch1
    enable_i = 4'b0010;
    drift_detected_i[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("sat_acc1_%0d", i), dut.acc_q[1], (i + 1 > 7) ? 7 : i + 1);
    end
    drift_detected_i = '0;
    max_drift_i = 4'd5; #1;
    check_eq("ovf_thr5", overflow_o, 4'b0010);
    max_drift_i = 4'd7; #1;
    check_eq("ovf_thr7", overflow_o, 0);
    clear_i[1] = 1'b1; tick(); clear_i = '0;
    check_eq("clear_acc1", dut.acc_q[1], 0);

    // clk_en low holds state
    clk_en = 1'b0; drift_detected_i[1] = 1'b1; tick();
    check_eq("clken_hold_acc1", dut.acc_q[1], 0);
    clk_en = 1'b1; drift_detected_i = '0;

    // arbitration between ch0 and ch2
    enable_i = 4'b0101;
    drift_detected_i = 4'b0101; drift_late_i = '1;
    repeat (2) tick();
    drift_detected_i = '0;
    check_eq("arb_setup_acc0", dut.acc_q[0], 2);
    check_eq("arb_setup_acc2", dut.acc_q[2], 2);
    min_lockout_i = 8'd0; corr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("arb_valid_%0d", i), corr_valid_o, arb_valid[i]);
      if (arb_valid[i]) begin
        check_eq($sformatf("arb_chan_%0d", i), corr_channel_o, arb_chan[i]);
        check_eq($sformatf("arb_late_%0d", i), corr_late_o, 1);
      end
    end
    corr_ready_i = 1'b0;
    check_eq("arb_end_acc0", dut.acc_q[0], 0);
    check_eq("arb_end_acc2", dut.acc_q[2], 0);
    check_eq("arb_end_rr", dut.rr_ptr, 3);

    // lockout gating on ch3
    enable_i = 4'b1000; min_lockout_i = 8'd3;
    drift_detected_i[3] = 1'b1; drift_late_i[3] = 1'b0; tick();
    drift_detected_i = '0; drift_late_i = '1;
    check_eq("lock_acc3", dut.acc_q[3], -1);
    any_valid_edge_i[3] = 1'b1;
    tick(); check_eq("lock_edge1_valid", corr_valid_o, 0);
    tick(); check_eq("lock_edge2_valid", corr_valid_o, 0);
    tick();
    any_valid_edge_i = '0;
    tick();
    check_eq("lock_offer_valid", corr_valid_o, 1);
    check_eq("lock_offer_chan", corr_channel_o, 3);
    check_eq("lock_offer_late", corr_late_o, 0);
    corr_ready_i = 1'b1; tick(); corr_ready_i = 1'b0;
    check_eq("lock_acc_valid", corr_valid_o, 0);
    check_eq("lock_acc_acc3", dut.acc_q[3], 0);
    check_eq("lock_acc_rr", dut.rr_ptr, 0);

    // retraction of a ch0 offer
    enable_i = 4'b0001; min_lockout_i = 8'd1;
    drift_detected_i[0] = 1'b1; tick(); drift_detected_i = '0;
    min_lockout_i = 8'd0; tick();
    check_eq("retr_valid_on", corr_valid_o, 1);
    check_eq("retr_chan", corr_channel_o, 0);
    tick();
    check_eq("retr_hold", corr_valid_o, 1);
    drift_detected_i[0] = 1'b1; drift_late_i[0] = 1'b0; tick();
    drift_detected_i = '0; drift_late_i = '1;
    check_eq("retr_valid_off", corr_valid_o, 0);
    check_eq("retr_acc0", dut.acc_q[0], 0);
    check_eq("retr_rr", dut.rr_ptr, 0);
    tick();
    check_eq("retr_stay_off", corr_valid_o, 0);

    // clk_en low during an offer: valid holds, ready ignored
    drift_detected_i[0] = 1'b1; tick(); drift_detected_i = '0;
    tick();
    check_eq("ce_offer", corr_valid_o, 1);
    clk_en = 1'b0; corr_ready_i = 1'b1; drift_detected_i[0] = 1'b1; tick();
    check_eq("ce_valid_hold", corr_valid_o, 1);
    check_eq("ce_acc_hold", dut.acc_q[0], 1);
    clk_en = 1'b1; drift_detected_i = '0; tick(); corr_ready_i = 1'b0;
    check_eq("ce_accept_valid", corr_valid_o, 0);
    check_eq("ce_accept_acc", dut.acc_q[0], 0);
    check_eq("ce_accept_rr", dut.rr_ptr, 1);

    // reset in the middle of an offer
    drift_detected_i[0] = 1'b1; tick(); drift_detected_i = '0;
    tick();
    check_eq("mid_rst_offer", corr_valid_o, 1);
    sync_rst_n = 1'b0; tick(); sync_rst_n = 1'b1;
    check_eq("mid_rst_valid", corr_valid_o, 0);
    check_eq("mid_rst_acc0", dut.acc_q[0], 0);
    check_eq("mid_rst_rr", dut.rr_ptr, 0);

`ifdef DRIFT_ACC_INVERSE_VIOLATION_EN
    // inverse-direction detection on ch1
    enable_i = 4'b0010; min_lockout_i = 8'd255;
    drift_detected_i[1] = 1'b1; repeat (2) tick();
    check_eq("viol_setup_acc1", dut.acc_q[1], 2);
    drift_late_i[1] = 1'b0; tick();
    drift_detected_i = '0; drift_late_i = '1;
    check_eq("viol_pulse", inverse_violation_o, 4'b0010);
    check_eq("viol_acc1", dut.acc_q[1], 0);
    tick();
    check_eq("viol_pulse_end", inverse_violation_o, 0);
    check_eq("viol_no_offer", corr_valid_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/drift_accumulator_mc.md
# drift_accumulator_mc

Multi-channel, signed successor to the single-channel drift accumulator in the clks_alot clock-recovery path. Each channel keeps a signed net-drift count (late positive, early negative) with saturation, a per-channel edge lockout, and an overflow flag. A round-robin arbiter offers one one-step correction at a time to the shared phase adjuster over a valid/ready handshake.

## Interface
- CHANNELS, 4: number of independent drift channels, at least 1.
- COUNTER_WIDTH, 8: signed accumulator width, at least 2.
- LOCKOUT_WIDTH, 8: unsigned per-channel lockout edge-counter width.
- Derived: IDX_W = max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- sync_rst_n  in  1  synchronous reset, active-low.
- clk_en  in  1  qualifies every state update and handshake acceptance.
- enable_i  in  CHANNELS  per-channel enable.
- clear_i  in  CHANNELS  per-channel state clear.
- drift_detected_i  in  CHANNELS  one drift event per cycle per channel.
- drift_late_i  in  CHANNELS  event direction: 1 = pin came late, 0 = pin came early.
- any_valid_edge_i  in  CHANNELS  valid edge seen on the channel; advances the lockout counter.
- max_drift_i  in  COUNTER_WIDTH  unsigned overflow threshold, shared by all channels.
- min_lockout_i  in  LOCKOUT_WIDTH  minimum edges required between corrections on a channel.
- overflow_o  out  CHANNELS  |acc[ch]| > max_drift_i, combinational from registered state.
- inverse_violation_o  out  CHANNELS  one-cycle pulse. Exists only when DRIFT_ACC_INVERSE_VIOLATION_EN is defined.
- corr_valid_o  out  1  correction offered.
- corr_ready_i  in  1  adjuster accepts the offered correction.
- corr_channel_o  out  IDX_W  channel of the offered correction.
- corr_late_o  out  1  1 = retard (acc positive), 0 = advance (acc negative).

## Operation
- acc[ch] is two's complement and saturates at ±(2^(COUNTER_WIDTH-1)-1). The most-negative code never occurs.
- Per-channel delta is evaluated in COUNTER_WIDTH+1 bits and clamped to that range:
  - Detection with enable_i high: +1 if late, −1 if early.
  - Accepted correction on this channel: −1 if corr_late_o, +1 otherwise.
  - A detection and an acceptance in the same cycle are both applied.
- Priority per channel: reset, then clear_i, then violation, then the arithmetic update. Clear sets acc = 0 and lockout = 0.
- lockout[ch]:
  - Increments on any_valid_edge_i and saturates at its all-ones value.
  - Zeroed by reset, by clear, or by acceptance of a correction on that channel.
  - Acceptance wins over a simultaneous edge.
- A channel is eligible when enable_i = 1, acc ≠ 0, and lockout ≥ min_lockout_i.
- Arbiter FSM has two states:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after rr_ptr (wrapping). Register its channel and sign into corr_channel_o and corr_late_o, then go to OFFER.
  - OFFER: corr_valid_o = 1, with channel and direction held stable.
    - If clk_en and corr_ready_i: the correction is accepted; rr_ptr = granted + 1 (wrapping to 0 after CHANNELS−1); go to IDLE.
    - Retraction: if the held channel's acc reaches 0, or it is cleared or disabled, go to IDLE without acceptance. rr_ptr is unchanged. This is the only case in which valid drops without ready.
- Reset values:
  - acc = 0, lockout = 0, rr_ptr = 0, FSM = IDLE.
  - All outputs 0.

## Timing
- Detection to acc update: 1 cycle.
- Eligibility to corr_valid_o: 1 cycle, because the FSM grants in IDLE and offers in OFFER.
- After an acceptance the FSM spends at least one cycle in IDLE, so back-to-back offers are 2 cycles apart.
- overflow_o follows acc combinationally in the cycle after the update.
- When clk_en is low: all state holds; corr_valid_o holds; ready is ignored.
- Reset mid-offer: corr_valid_o = 0 on the cycle after sync_rst_n is sampled low.

## Configuration
- DRIFT_ACC_INVERSE_VIOLATION_EN defined:
  - A detection whose direction opposes a nonzero acc sign does not cancel.
  - Instead it pulses inverse_violation_o[ch] for one cycle and zeroes acc[ch] and lockout[ch].
  - If that channel is held in OFFER, the offer retracts.
- Not defined:
  - Opposite detections simply add, so they cancel drift.
  - inverse_violation_o is absent.

## Test plan
- Reset with the macro undefined: hold sync_rst_n = 0 for 2 cycles with detections toggling → all outputs 0. Three late detections on ch0 → acc[0] = 3.
- Saturation: COUNTER_WIDTH = 4, 10 late detections on ch1 → acc = +7 and stays there. With max_drift_i = 5, overflow_o[1] = 1.
- Arbitration: acc = 2 on ch0 and ch2, min_lockout_i = 0, corr_ready_i held high → offers go ch0, ch2, ch0, ch2 at 2-cycle spacing, then valid stays low. Both accumulators end at 0.
- Lockout: min_lockout_i = 3, acc[3] = −1 → no offer until the third any_valid_edge_i. The next cycle shows valid = 1, channel = 3, late = 0.
- Retraction: ch0 in OFFER with acc = +1, ready held low, one early detection → valid drops the next cycle and rr_ptr is unchanged.
- Macro defined: acc[1] = +2, early detection → inverse_violation_o[1] pulses once, acc[1] = 0, and no offer is made.
